// File: rtl/cla_nibble_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cla_nibble_seq_ctrl
// Brief    : WIDTH-bit add/subtract sequencer around an external 4-bit CLA slice
// Revision : 1.0
// ============================================================================
module cla_nibble_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic [3:0]       adder_a,
    output logic [3:0]       adder_b,
    output logic             adder_ci,
    input  logic [3:0]       adder_s,
    input  logic             adder_co,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  result_q;
    logic [WIDTH-1:0]  result_d;
    logic              carry_q;
    logic              carry_out_q;
    logic              overflow_q;
    logic [IDXW-1:0]   idx_q;

    logic [3:0]        a_nib [NIB];
    logic [3:0]        b_nib [NIB];

    for (genvar n = 0; n < NIB; n++) begin : g_nib
        assign a_nib[n] = a_q[4*n +: 4];
        assign b_nib[n] = b_q[4*n +: 4];
    end

    // Result with the current nibble replaced by the slice sum.
    always_comb begin
        result_d = result_q;
        for (int n = 0; n < NIB; n++) begin
            if (idx_q == IDXW'(n)) begin
                result_d[4*n +: 4] = adder_s;
            end
        end
    end

    assign adder_a  = (state_q == S_RUN) ? a_nib[idx_q] : 4'd0;
    assign adder_b  = (state_q == S_RUN) ? b_nib[idx_q] : 4'd0;
    assign adder_ci = (state_q == S_RUN) ? carry_q      : 1'b0;

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            idx_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        // Subtraction as A + ~B + 1: invert B, seed carry with 1.
                        a_q      <= op_a;
                        b_q      <= sub ? ~op_b : op_b;
                        carry_q  <= sub;
                        idx_q    <= '0;
                        result_q <= '0;
                        state_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    result_q <= result_d;
                    carry_q  <= adder_co;
                    if (idx_q == C_LAST_IDX) begin
                        carry_out_q <= adder_co;
                        overflow_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                       (adder_s[3] != a_q[WIDTH-1]);
                        idx_q       <= '0;
                        state_q     <= S_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cla_nibble_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_nibble_seq_ctrl
// Brief    : Scoreboard bench for cla_nibble_seq_ctrl with a modelled CLA slice
// Revision : 1.0
// ============================================================================
module tb_cla_nibble_seq_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = 4;

    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
    } exp_t;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             sub       = 1'b0;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] op_a      = '0;
    logic [WIDTH-1:0] op_b      = '0;
    logic             in_ready;
    logic [3:0]       adder_a;
    logic [3:0]       adder_b;
    logic             adder_ci;
    logic [3:0]       adder_s;
    logic             adder_co;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             busy;
    logic [4:0]       slice_sum;

    exp_t sb [$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [3:0] ci_seq;
    logic [3:0] co_seq;
    logic [3:0] b_first;
    logic       seen_valid;

    always #5 clk = ~clk;

    // Combinational 4-bit slice the sequencer time-multiplexes.
    assign slice_sum = {1'b0, adder_a} + {1'b0, adder_b} + {4'b0, adder_ci};
    assign adder_s   = slice_sum[3:0];
    assign adder_co  = slice_sum[4];

    cla_nibble_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .adder_a   (adder_a),
        .adder_b   (adder_b),
        .adder_ci  (adder_ci),
        .adder_s   (adder_s),
        .adder_co  (adder_co),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [WIDTH-1:0] r, input logic c, input logic v);
        exp_t e;
        e.r = r;
        e.c = c;
        e.v = v;
        return e;
    endfunction

    // Drive an operand pair and wait for its acceptance edge; returns 1 ns after it.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic s, input bit push, input exp_t e);
        int t;
        @(posedge clk);
        #1;
        op_a     = a;
        op_b     = b;
        sub      = s;
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("accept_timeout", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        if (push) sb.push_back(e);
        #1;
        in_valid = 1'b0;
    endtask

    // Observe the NIB RUN cycles, then the first DONE cycle.
    task automatic run_obs(output logic [3:0] ci, output logic [3:0] co, output logic [3:0] b0);
        ci = '0;
        co = '0;
        b0 = '0;
        for (int k = 0; k < NIB; k++) begin
            @(negedge clk);
            ci[k] = adder_ci;
            co[k] = adder_co;
            if (k == 0) b0 = adder_b;
            chk("in_ready_in_run", {31'b0, in_ready}, 32'd0);
        end
        chk("out_valid_early", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        chk("out_valid_latency", {31'b0, out_valid}, 32'd1);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("result",    {16'b0, result},    {16'b0, mon_e.r});
                    chk("carry_out", {31'b0, carry_out}, {31'b0, mon_e.c});
                    chk("overflow",  {31'b0, overflow},  {31'b0, mon_e.v});
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        #3;
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("rst_busy",      {31'b0, busy},      32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result",    {16'b0, result},    32'd0);
        chk("rst_flags",     {30'b0, carry_out, overflow}, 32'd0);
        chk("rst_adder",     {23'b0, adder_a, adder_b, adder_ci}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        start_op(16'h1234, 16'h0FED, 1'b0, 1'b1, mk(16'h2221, 1'b0, 1'b0));
        run_obs(ci_seq, co_seq, b_first);
        chk("v1_ci_seq", {28'b0, ci_seq}, 32'b1110);

        start_op(16'hFFFF, 16'h0001, 1'b0, 1'b1, mk(16'h0000, 1'b1, 1'b0));
        run_obs(ci_seq, co_seq, b_first);
        chk("v2_co_seq", {28'b0, co_seq}, 32'b1111);

        start_op(16'h0005, 16'h0007, 1'b1, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
        run_obs(ci_seq, co_seq, b_first);
        chk("v3_first_ci", {31'b0, ci_seq[0]}, 32'd1);
        chk("v3_first_b",  {28'b0, b_first},   32'h8);

        start_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, mk(16'h8000, 1'b0, 1'b1));
        run_obs(ci_seq, co_seq, b_first);

        start_op(16'h8000, 16'h0001, 1'b1, 1'b1, mk(16'h7FFF, 1'b1, 1'b1));
        run_obs(ci_seq, co_seq, b_first);

        // Backpressure with a new pair held on the input the whole time.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        start_op(16'h0100, 16'h0200, 1'b0, 1'b1, mk(16'h0300, 1'b0, 1'b0));
        op_a     = 16'h1111;
        op_b     = 16'h2222;
        sub      = 1'b0;
        in_valid = 1'b1;
        run_obs(ci_seq, co_seq, b_first);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_in_ready",  {31'b0, in_ready},  32'd0);
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_result",    {16'b0, result},    32'h0300);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_after", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        sb.push_back(mk(16'h3333, 1'b0, 1'b0));
        #1;
        in_valid = 1'b0;
        run_obs(ci_seq, co_seq, b_first);

        // Reset asserted in the second RUN cycle.
        start_op(16'h1234, 16'h1111, 1'b0, 1'b0, mk(16'h0000, 1'b0, 1'b0));
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("mid_rst_busy",      {31'b0, busy},      32'd0);
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_result",    {16'b0, result},    32'd0);
        chk("mid_rst_adder",     {23'b0, adder_a, adder_b, adder_ci}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen_valid = seen_valid | out_valid;
        end
        chk("no_out_after_reset", {31'b0, seen_valid}, 32'd0);

        start_op(16'h0001, 16'h0001, 1'b0, 1'b1, mk(16'h0002, 1'b0, 1'b0));
        run_obs(ci_seq, co_seq, b_first);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
